// File: rtl/data_ram_resp_pkg.sv
// Shared widths and store-buffer entry layout for the data-RAM responder.
// Optional: WB_COALESCE_EN merges a write into an existing matching entry.
package data_ram_resp_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int IDX_MAX_W = ADDR_W - 2;
  localparam int WB_DEPTH_DEF = 4;

  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/data_ram_wbuf.sv
// Store buffer: circular FIFO with a youngest-match index CAM.
// With WB_COALESCE_EN a write hitting a live entry updates it in place.
module data_ram_wbuf
  import data_ram_resp_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEF,
  localparam int PW = $clog2(WB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [IDX_MAX_W-1:0] push_idx,
  input  logic [DATA_W-1:0]    push_data,
  input  logic                 pop,
  input  logic [IDX_MAX_W-1:0] fwd_idx,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data,
  output wb_entry_t            head,
  output logic [PW:0]          count,
  output logic                 drop
);

  wb_entry_t ent_q [WB_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;
  logic [PW-1:0] p, fwd_ptr, wr_ptr;
  logic          wr_hit, coal, full, alloc;

  // Scan oldest to youngest so the last hit wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_ptr = '0;
    wr_hit  = 1'b0;
    wr_ptr  = '0;
    p       = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      p = head_q + PW'(i);
      if (ent_q[p].valid && ent_q[p].idx == fwd_idx) begin
        fwd_hit = 1'b1;
        fwd_ptr = p;
      end
      if (ent_q[p].valid && ent_q[p].idx == push_idx) begin
        wr_hit = 1'b1;
        wr_ptr = p;
      end
    end
  end

`ifdef WB_COALESCE_EN
  assign coal = push && wr_hit;
`else
  assign coal = 1'b0;
`endif

  assign full  = count_q == (PW+1)'(WB_DEPTH);
  assign alloc = push && !coal && (!full || pop);
  assign drop  = push && !coal && full && !pop;

  always_comb begin
    head = ent_q[head_q];
    if (coal && wr_ptr == head_q)
      head.data = push_data;
  end

  assign fwd_data = ent_q[fwd_ptr].data;
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < WB_DEPTH; i++)
        ent_q[i].valid <= 1'b0;
    end else begin
      if (coal)
        ent_q[wr_ptr].data <= push_data;
      if (pop) begin
        ent_q[head_q].valid <= 1'b0;
        head_q <= head_q + 1'b1;
      end
      if (alloc) begin
        ent_q[tail_q] <= '{valid: 1'b1,
                           idx: push_idx,
                           data: push_data};
        tail_q <= tail_q + 1'b1;
      end
      count_q <= count_q + (PW+1)'(alloc)
                         - (PW+1)'(pop);
    end
  end

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: combinational reads, buffered writes drained
// in read-free cycles. Optional: WB_COALESCE_EN (see data_ram_wbuf).
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int WB_DEPTH   = WB_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      re,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [DATA_W-1:0]         rdata,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [$clog2(WB_DEPTH):0] wb_count,
  output logic                      wb_empty
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] ridx, widx;
  logic rd, wr, pop, fwd_hit, drop;
  logic [DATA_W-1:0] fwd_data;
  wb_entry_t head;
  logic [$clog2(WB_DEPTH):0] count;

  assign ridx = raddr[DEPTH_LOG2+1:2];
  assign widx = waddr[DEPTH_LOG2+1:2];
  assign rd   = !rst && ce && re;
  assign wr   = !rst && ce && we;

  // A served read owns the single array port.
  assign pop = !rst && !rd && (count != '0);

  data_ram_wbuf #(.WB_DEPTH(WB_DEPTH)) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (wr),
    .push_idx  (IDX_MAX_W'(widx)),
    .push_data (wdata),
    .pop       (pop),
    .fwd_idx   (IDX_MAX_W'(ridx)),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .head      (head),
    .count     (count),
    .drop      (drop)
  );

  always_comb begin
    rdata = '0;
    if (rd)
      rdata = fwd_hit ? fwd_data : mem[ridx];
  end

  always_ff @(posedge clk) begin
    if (pop)
      mem[head.idx[DEPTH_LOG2-1:0]] <= head.data;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!drop);
  end

  assign wb_count = count;
  assign wb_empty = count == '0;

  logic unused_ok;
  assign unused_ok = ^{raddr[1:0], raddr[ADDR_W-1:DEPTH_LOG2+2],
                       waddr[1:0], waddr[ADDR_W-1:DEPTH_LOG2+2],
                       head.valid,
                       head.idx[IDX_MAX_W-1:DEPTH_LOG2]};

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed plus randomized bench for data_ram_resp against a queue model.
// Build with +define+WB_COALESCE_EN to check the coalescing variant.
module tb_data_ram_resp;

  logic        clk = 1'b0;
  logic        rst, ce, re, we;
  logic [31:0] raddr, waddr, wdata, rdata;
  logic [2:0]  wb_count;
  logic        wb_empty;

  data_ram_resp dut (
    .clk(clk), .rst(rst), .ce(ce), .re(re),
    .raddr(raddr), .rdata(rdata), .we(we),
    .waddr(waddr), .wdata(wdata),
    .wb_count(wb_count), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mem_m [1024];
  bit          known [1024];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rd;

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit c,
                     input bit rd_e, input bit wr_e,
                     input logic [31:0] ra,
                     input logic [31:0] wa,
                     input logic [31:0] wd);
    logic [31:0] exp;
    bit          exp_ok, coal, hit;
    ent_t        e;
    rst = r; ce = c; re = rd_e; we = wr_e;
    raddr = ra; waddr = wa; wdata = wd;
    #1;
    last_rd = rdata;
    exp = '0;
    exp_ok = 1'b1;
    if (!r && c && rd_e) begin
      hit = 1'b0;
      for (int k = q.size() - 1; k >= 0 && !hit; k--)
        if (q[k].idx == widx(ra)) begin
          exp = q[k].data;
          hit = 1'b1;
        end
      if (!hit) begin
        exp_ok = known[widx(ra)];
        exp = mem_m[widx(ra)];
      end
    end
    if (exp_ok) chk("rdata", rdata, exp);
    @(posedge clk);
    if (r) q.delete();
    else begin
      coal = 1'b0;
`ifdef WB_COALESCE_EN
      if (c && wr_e)
        foreach (q[k])
          if (q[k].idx == widx(wa)) begin
            q[k].data = wd;
            coal = 1'b1;
          end
`endif
      if (!(c && rd_e) && q.size() > 0) begin
        e = q.pop_front();
        mem_m[e.idx] = e.data;
        known[e.idx] = 1'b1;
      end
      if (c && wr_e && !coal && q.size() < 4)
        q.push_back('{widx(wa), wd});
    end
    #1;
    chk("wb_count", 32'(wb_count), 32'(q.size()));
    chk("wb_empty", 32'(wb_empty), 32'(q.size() == 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    logic [31:0] ra, wa;
    bit          r, c, rr, ww;
    foreach (known[i]) known[i] = 1'b0;

    cyc(1, 0, 0, 0, '0, '0, '0);
    cyc(1, 0, 0, 0, '0, '0, '0);
    chk("rst_empty", 32'(wb_empty), 32'd1);
    chk("rst_count", 32'(wb_count), 32'd0);

    // 1: write, drain, read back
    cyc(0, 1, 0, 1, '0, 32'h100, 32'hDEADBEEF);
    chk("t1_cnt1", 32'(wb_count), 32'd1);
    idle(1);
    chk("t1_cnt0", 32'(wb_count), 32'd0);
    cyc(0, 1, 1, 0, 32'h100, '0, '0);
    chk("t1_rd", last_rd, 32'hDEADBEEF);

    // 2: fill without drains, forward, full+write
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 1, 1, 32'h40, 32'h10 + 4*i, 32'hA0 + i);
    chk("t2_full", 32'(wb_count), 32'd4);
    cyc(0, 1, 1, 0, 32'h14, '0, '0);
    chk("t2_fwd", last_rd, 32'hA1);
    cyc(0, 1, 0, 1, '0, 32'h60, 32'h55);
    chk("t2_cnt4", 32'(wb_count), 32'd4);
    idle(5);

    // 3: youngest match
    cyc(0, 1, 0, 1, '0, 32'h20, 32'd1);
    cyc(0, 1, 1, 1, 32'h100, 32'h20, 32'd2);
`ifdef WB_COALESCE_EN
    chk("t3_cnt", 32'(wb_count), 32'd1);
`else
    chk("t3_cnt", 32'(wb_count), 32'd2);
`endif
    cyc(0, 1, 1, 0, 32'h20, '0, '0);
    chk("t3_rd", last_rd, 32'd2);
    idle(3);

    // 4: reset discards undrained writes only
    cyc(0, 1, 0, 1, '0, 32'h30, 32'h111);
    idle(1);
    cyc(0, 1, 0, 1, '0, 32'h30, 32'h222);
    cyc(0, 1, 1, 1, 32'h100, 32'h34, 32'h333);
    cyc(0, 1, 1, 1, 32'h100, 32'h38, 32'h444);
    chk("t4_cnt3", 32'(wb_count), 32'd3);
    cyc(1, 1, 1, 1, 32'h30, 32'h3C, 32'h999);
    chk("t4_rst_rd", last_rd, 32'd0);
    chk("t4_empty", 32'(wb_empty), 32'd1);
    cyc(0, 1, 1, 0, 32'h30, '0, '0);
    chk("t4_old", last_rd, 32'h111);

    // 5: ce=0 ignores requests, drain continues
    cyc(0, 1, 0, 1, '0, 32'h44, 32'd7);
    cyc(0, 1, 1, 1, 32'h30, 32'h48, 32'd8);
    cyc(0, 0, 1, 1, 32'h30, 32'h30, 32'hBAD);
    chk("t5_rd0", last_rd, 32'd0);
    chk("t5_cnt1", 32'(wb_count), 32'd1);
    cyc(0, 0, 1, 1, 32'h30, 32'h30, 32'hBAD);
    chk("t5_cnt0", 32'(wb_count), 32'd0);
    cyc(0, 1, 1, 0, 32'h30, '0, '0);
    chk("t5_noenq", last_rd, 32'h111);
    cyc(0, 1, 1, 0, 32'h48, '0, '0);
    chk("t5_drain", last_rd, 32'd8);

    // 6: aliasing of upper address bits
    cyc(0, 1, 0, 1, '0, 32'h1000_0104, 32'hCAFE0104);
    idle(1);
    cyc(0, 1, 1, 0, 32'h104, '0, '0);
    chk("t6_alias", last_rd, 32'hCAFE0104);

    // randomized traffic over a small aliased word set
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 15) << 2) | ($urandom & 32'h3)
         | (($urandom % 4) << 12);
      wa = ($urandom_range(0, 15) << 2) | ($urandom & 32'h3)
         | (($urandom % 4) << 12);
      r  = ($urandom % 50) == 0;
      c  = ($urandom % 8) != 0;
      rr = $urandom % 2;
      ww = $urandom % 2;
      if (c && rr && ww && q.size() == 4) ww = 1'b0;
      cyc(r, c, rr, ww, ra, wa, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
